toggle_bank_arbiter: RTL

- Round-robin arbiter and sequencer that shares one bank of NBITS toggle/set/clear flip-flops among NREQ requesters.
- Each requester presents an opcode and a bit index. The arbiter grants one requester at a time, applies the operation to the shared bank, then returns a one-cycle acknowledge.
- Opcode 00 is a legal no-op: the request is acknowledged and the bank is left untouched.
- The block sits between independent control agents and the shared toggle-register resource. It is fully synthesizable.

---
 rtl/toggle_bank_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/toggle_bank_arbiter.sv
// Round-robin arbiter sharing one toggle/set/clear bank among NREQ agents.
// Each grant runs IDLE -> EXEC -> ACK, then the pointer moves past the winner.
module toggle_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int NBITS = 8,
  parameter int IDXW  = 3
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [NREQ-1:0]      req,
  input  logic [2*NREQ-1:0]    op,
  input  logic [IDXW*NREQ-1:0] idx,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      ack,
  output logic                 err,
  output logic                 busy,
  output logic [NBITS-1:0]     q,
  output logic [7:0]           cnt
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    ACK
  } state_t;

  state_t state, state_d;

  logic [PW-1:0]    ptr, ptr_d;
  logic [PW-1:0]    win, win_d;
  logic [PW-1:0]    pick;
  logic             found;
  logic [1:0]       opl, opl_d;
  logic [IDXW-1:0]  idxl, idxl_d;
  logic [NBITS-1:0] q_d;
  logic [NBITS-1:0] mask;
  logic [7:0]       cnt_d;
  logic [NREQ-1:0]  gnt_d, ack_d;
  logic             err_d;
  logic             valid;

  // First set request at or above the pointer, wrapping.
  always_comb begin : pick_b
    int j;
    j     = 0;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      j = (int'(ptr) + i) % NREQ;
      if (!found && req[j]) begin
        pick  = PW'(j);
        found = 1'b1;
      end
    end
  end

  assign valid = 32'(idxl) < NBITS;
  assign mask  = valid ? (NBITS'(1) << idxl) : '0;
  assign busy  = (state != IDLE);

  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    win_d   = win;
    opl_d   = opl;
    idxl_d  = idxl;
    q_d     = q;
    cnt_d   = cnt;
    gnt_d   = gnt;
    ack_d   = ack;
    err_d   = err;
    unique case (state)
      IDLE: begin
        if (found) begin
          win_d   = pick;
          opl_d   = op[2*pick +: 2];
          idxl_d  = idx[IDXW*pick +: IDXW];
          gnt_d   = NREQ'(1) << pick;
          state_d = EXEC;
        end
      end
      EXEC: begin
        unique case (opl)
          2'b00: ;
          2'b01: begin
            q_d = q ^ mask;
            if (valid) cnt_d = cnt + 8'd1;
          end
          2'b10: q_d = q & ~mask;
          2'b11: q_d = q | mask;
        endcase
        ack_d   = NREQ'(1) << win;
        err_d   = !valid;
        state_d = ACK;
      end
      ACK: begin
        gnt_d   = '0;
        ack_d   = '0;
        err_d   = 1'b0;
        ptr_d   = (win == PW'(NREQ-1)) ? '0 : win + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
      ptr   <= '0;
      win   <= '0;
      opl   <= '0;
      idxl  <= '0;
      q     <= '0;
      cnt   <= '0;
      gnt   <= '0;
      ack   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_d;
      ptr   <= ptr_d;
      win   <= win_d;
      opl   <= opl_d;
      idxl  <= idxl_d;
      q     <= q_d;
      cnt   <= cnt_d;
      gnt   <= gnt_d;
      ack   <= ack_d;
      err   <= err_d;
    end
  end

endmodule
